// File: rtl/crop_window_stream.sv
// crop_window_stream: forwards a configurable, optionally decimated crop window of a raster frame
// through a 2-entry output FIFO with an end-of-window marker.
module crop_window_stream #(
    parameter int PIXEL_BIT_WIDTH = 12,
    parameter int CHANNELS = 1,
    parameter int IN_ROWS = 40,
    parameter int IN_COLS = 40,
    parameter int STEP_W = 3,
    localparam int DW = CHANNELS * PIXEL_BIT_WIDTH,
    localparam int RW = $clog2(IN_ROWS),
    localparam int CW = $clog2(IN_COLS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [RW-1:0]     cfg_y1,
    input  logic [CW-1:0]     cfg_x1,
    input  logic [RW:0]       cfg_rows,
    input  logic [CW:0]       cfg_cols,
    input  logic [STEP_W-1:0] cfg_step,
    output logic              cfg_error,
    input  logic [DW-1:0]     in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DW-1:0]     out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              frame_done
);
    localparam int YW = RW + STEP_W + 2;
    localparam int XW = CW + STEP_W + 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state;

    logic [STEP_W-1:0] cfg_step_eff, step, rph, cph;
    logic [YW-1:0] y_end;
    logic [XW-1:0] x_end;
    logic [RW-1:0] y1, row, row_next;
    logic [CW-1:0] x1, col, col_next;
    logic [RW:0] rows, wrow;
    logic [CW:0] cols, wcol;
    logic [1:0] count;
    logic [DW-1:0] slot_data;
    logic slot_last, cfg_legal, in_fire, pop, keep, last, push, col_wrap, end_pix, rph_wrap, cph_wrap;

    always_comb begin
        cfg_step_eff = cfg_step == '0 ? STEP_W'(1) : cfg_step;
        y_end = YW'(cfg_y1) + YW'(cfg_rows - (RW + 1)'(1)) * YW'(cfg_step_eff);
        x_end = XW'(cfg_x1) + XW'(cfg_cols - (CW + 1)'(1)) * XW'(cfg_step_eff);
        cfg_legal = cfg_rows != '0 && cfg_cols != '0 && y_end <= YW'(IN_ROWS - 1) && x_end <= XW'(IN_COLS - 1);
        in_ready = state == RUN && count != 2'd2;
        out_valid = count != 2'd0;
        in_fire = in_valid && in_ready;
        pop = out_valid && out_ready;
        keep = row >= y1 && wrow < rows && rph == '0 && col >= x1 && wcol < cols && cph == '0;
        last = wrow == rows - (RW + 1)'(1) && wcol == cols - (CW + 1)'(1);
        push = in_fire && keep;
        col_wrap = col == CW'(IN_COLS - 1);
        end_pix = col_wrap && row == RW'(IN_ROWS - 1);
        col_next = col_wrap ? '0 : col + CW'(1);
        row_next = row + RW'(1);
        rph_wrap = rph == step - STEP_W'(1);
        cph_wrap = cph == step - STEP_W'(1);
    end

    // Phase counters restart at the window origin; wrow/wcol count completed decimation steps.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cfg_ready <= 1'b0;
            cfg_error <= 1'b0;
            frame_done <= 1'b0;
            y1 <= '0;
            x1 <= '0;
            rows <= '0;
            cols <= '0;
            step <= '0;
            row <= '0;
            col <= '0;
            rph <= '0;
            cph <= '0;
            wrow <= '0;
            wcol <= '0;
        end else begin
            cfg_error <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    cfg_ready <= !(cfg_valid && cfg_ready && cfg_legal);
                    if (cfg_valid && cfg_ready && cfg_legal) begin
                        y1 <= cfg_y1;
                        x1 <= cfg_x1;
                        rows <= cfg_rows;
                        cols <= cfg_cols;
                        step <= cfg_step_eff;
                        row <= '0;
                        col <= '0;
                        rph <= '0;
                        cph <= '0;
                        wrow <= '0;
                        wcol <= '0;
                        state <= RUN;
                    end else if (cfg_valid && cfg_ready) begin
                        cfg_error <= 1'b1;
                    end
                end
                RUN: if (in_fire) begin
                    col <= col_next;
                    if (col_next == x1) begin
                        cph <= '0;
                        wcol <= '0;
                    end else if (col >= x1) begin
                        cph <= cph_wrap ? '0 : cph + STEP_W'(1);
                        wcol <= wcol + (CW + 1)'(cph_wrap);
                    end
                    if (col_wrap) begin
                        row <= row_next;
                        if (row_next == y1) begin
                            rph <= '0;
                            wrow <= '0;
                        end else if (row >= y1) begin
                            rph <= rph_wrap ? '0 : rph + STEP_W'(1);
                            wrow <= wrow + (RW + 1)'(rph_wrap);
                        end
                    end
                    if (end_pix) state <= DRAIN;
                end
                DRAIN: if (count == 2'd0) begin
                    frame_done <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Head register drives the outputs directly; slot holds the second entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 2'd0;
            out_data <= '0;
            out_last <= 1'b0;
            slot_data <= '0;
            slot_last <= 1'b0;
        end else begin
            count <= count + 2'(push) - 2'(pop);
            if (pop && count == 2'd2) {out_last, out_data} <= {slot_last, slot_data};
            else if (push && (count == 2'd0 || pop)) {out_last, out_data} <= {last, in_data};
            if (push && count == 2'd1 && !pop) {slot_last, slot_data} <= {last, in_data};
        end
    end
endmodule

// File: tb/tb_crop_window_stream.sv
// tb_crop_window_stream: directed and randomized frames checked against a raster-scan window model.
module tb_crop_window_stream;
    localparam int PBW = 12, CH = 3, R = 40, C = 40, SW = 3;
    localparam int DW = PBW * CH, RW = 6, CW = 6;

    logic clk = 1'b0, reset = 1'b1;
    logic cfg_valid = 1'b0, cfg_ready, cfg_error;
    logic [RW-1:0] cfg_y1 = '0;
    logic [CW-1:0] cfg_x1 = '0;
    logic [RW:0] cfg_rows = '0;
    logic [CW:0] cfg_cols = '0;
    logic [SW-1:0] cfg_step = '0;
    logic [DW-1:0] in_data = '0, out_data;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_last, frame_done;

    int passes = 0, checks = 0;
    logic [DW:0] exp_q[$];

    crop_window_stream #(.PIXEL_BIT_WIDTH(PBW), .CHANNELS(CH), .IN_ROWS(R), .IN_COLS(C), .STEP_W(SW)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_y1(cfg_y1), .cfg_x1(cfg_x1), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
        .cfg_step(cfg_step), .cfg_error(cfg_error), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] pix(input int idx);
        logic [DW-1:0] v;
        for (int c = 0; c < CH; c++) v[c*PBW +: PBW] = PBW'((idx + c * 1000) % 4096);
        return v;
    endfunction

    function automatic void build(input int y1, input int x1, input int rows, input int cols, input int step);
        int st = step == 0 ? 1 : step;
        exp_q.delete();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                if (r >= y1 && r < y1 + rows * st && (r - y1) % st == 0 &&
                    c >= x1 && c < x1 + cols * st && (c - x1) % st == 0)
                    exp_q.push_back({1'b0, pix(r * C + c)});
        if (exp_q.size() > 0) exp_q[exp_q.size() - 1][DW] = 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic config_frame(input int y1, input int x1, input int rows, input int cols, input int step);
        int st = step == 0 ? 1 : step;
        bit legal = rows >= 1 && cols >= 1 && y1 + (rows - 1) * st <= R - 1 && x1 + (cols - 1) * st <= C - 1;
        for (int i = 0; i < 20 && !cfg_ready; i++) tick();
        chk("cfg_ready_before_offer", cfg_ready, 1);
        cfg_y1 = RW'(y1);
        cfg_x1 = CW'(x1);
        cfg_rows = (RW + 1)'(rows);
        cfg_cols = (CW + 1)'(cols);
        cfg_step = SW'(step);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("cfg_error", cfg_error, !legal);
        chk("in_ready_after_cfg", in_ready, legal);
        if (!legal) begin
            in_valid = 1'b1;
            tick();
            chk("cfg_error_one_cycle", cfg_error, 0);
            for (int i = 0; i < 4; i++) begin
                chk("in_ready_rejected", in_ready, 0);
                chk("out_valid_rejected", out_valid, 0);
                tick();
            end
            in_valid = 1'b0;
        end
    endtask

    task automatic run(input bit rnd, input int abort_after);
        int p = 0, dones = 0, cyc = 0;
        bit fin = 0, in_hs, out_hs, stall;
        logic [DW:0] held, e;
        while (!fin && cyc < 20000) begin
            in_valid = rnd ? 1'($urandom % 2) : 1'b1;
            out_ready = rnd ? 1'($urandom % 2) : 1'b1;
            in_data = pix(p);
            in_hs = in_valid && in_ready;
            out_hs = out_valid && out_ready;
            if (out_hs) begin
                if (exp_q.size() == 0) chk("unexpected_output", {out_last, out_data}, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e[DW-1:0]);
                    chk("out_last", out_last, e[DW]);
                end
            end
            stall = out_valid && !out_ready;
            held = {out_last, out_data};
            tick();
            cyc++;
            if (in_hs) p++;
            if (stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_hold", {out_last, out_data}, held);
            end
            if (frame_done) begin
                dones++;
                fin = 1;
            end
            if (abort_after > 0 && p == abort_after) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        chk("frame_done_seen", fin, 1);
        chk("frame_done_count", dones, 1);
        chk("pixels_consumed", p, R * C);
        chk("outputs_missing", exp_q.size(), 0);
        chk("cfg_ready_at_done", cfg_ready, 0);
        tick();
        chk("frame_done_pulse", frame_done, 0);
        chk("cfg_ready_after_done", cfg_ready, 1);
        chk("in_ready_idle", in_ready, 0);
    endtask

    task automatic frame(input int y1, input int x1, input int rows, input int cols, input int step, input bit rnd);
        build(y1, x1, rows, cols, step);
        config_frame(y1, x1, rows, cols, step);
        run(rnd, 0);
    endtask

    initial begin
        int st, y1, x1, rows, cols;
        repeat (2) tick();
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_last", out_last, 0);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_cfg_ready", cfg_ready, 0);
        chk("reset_cfg_error", cfg_error, 0);
        chk("reset_frame_done", frame_done, 0);
        reset = 1'b0;
        tick();
        chk("cfg_ready_post_reset", cfg_ready, 1);

        frame(10, 10, 20, 20, 1, 0);
        frame(0, 0, 20, 20, 2, 0);
        frame(1, 2, 13, 12, 3, 0);
        frame(10, 10, 20, 20, 1, 1);
        build(10, 10, 20, 20, 1);
        config_frame(30, 10, 20, 20, 1);
        config_frame(10, 10, 20, 20, 1);
        run(0, 0);
        frame(5, 7, 4, 6, 0, 1);
        for (int k = 0; k < 3; k++) begin
            st = int'($urandom_range(1, 7));
            y1 = int'($urandom_range(0, R - 1));
            x1 = int'($urandom_range(0, C - 1));
            rows = int'($urandom_range(1, (R - 1 - y1) / st + 1));
            cols = int'($urandom_range(1, (C - 1 - x1) / st + 1));
            frame(y1, x1, rows, cols, st, 1);
        end

        build(10, 10, 20, 20, 1);
        config_frame(10, 10, 20, 20, 1);
        run(0, 500);
        reset = 1'b1;
        tick();
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_cfg_ready", cfg_ready, 0);
        chk("midreset_in_ready", in_ready, 0);
        tick();
        chk("midreset_hold_out_valid", out_valid, 0);
        chk("midreset_hold_cfg_ready", cfg_ready, 0);
        reset = 1'b0;
        tick();
        chk("cfg_ready_after_midreset", cfg_ready, 1);
        frame(10, 10, 20, 20, 1, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/crop_window_stream.md
# crop_window_stream

Runtime-configurable, multi-channel successor to `crop_filter`. It consumes a raster-order input frame of fixed size IN_ROWS×IN_COLS over a valid/ready stream. It forwards only the pixels inside a crop window, optionally decimated by an integer step. The window origin, size and step are loaded per frame through a config handshake. Output is buffered in a 2-entry FIFO, carries an end-of-window marker, and sits between the pixel source and downstream feature-extraction stages.

## Interface
- PIXEL_BIT_WIDTH, 12, bits per channel sample
- CHANNELS, 1, samples packed per pixel; channel c occupies bits [c*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH]
- IN_ROWS, 40, input frame rows
- IN_COLS, 40, input frame columns
- STEP_W, 3, width of step field
- Derived: DW = CHANNELS*PIXEL_BIT_WIDTH; RW = $clog2(IN_ROWS); CW = $clog2(IN_COLS)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cfg_valid  in  1  config offered
- cfg_ready  out  1  high only in IDLE and not in reset
- cfg_y1  in  RW  window top row
- cfg_x1  in  CW  window left column
- cfg_rows  in  RW+1  output rows, ≥1
- cfg_cols  in  CW+1  output columns, ≥1
- cfg_step  in  STEP_W  decimation step; 0 is treated as 1
- cfg_error  out  1  one-cycle pulse when offered config is rejected
- in_data  in  DW  input pixel
- in_valid  in  1  input valid
- in_ready  out  1  input accepted when in_valid && in_ready
- out_data  out  DW  output pixel
- out_valid  out  1  output valid
- out_ready  in  1  downstream ready
- out_last  out  1  qualifies the final window pixel, valid with out_valid
- frame_done  out  1  one-cycle pulse when the frame is fully drained

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: cfg_ready=1 and in_ready=0. On cfg_valid, the config is checked. It is legal when rows≥1, cols≥1, y1+(rows-1)*step ≤ IN_ROWS-1 and x1+(cols-1)*step ≤ IN_COLS-1.
  - Compute the checks at width RW+STEP_W+2 and CW+STEP_W+2 so they cannot overflow.
  - Legal config: latch all fields, clear the counters and go to RUN.
  - Illegal config: pulse cfg_error, stay in IDLE and latch nothing.
- RUN: in_ready = (fifo_count < 2). Every handshaked pixel advances the raster counters (row, col). col wraps at IN_COLS-1 and row then increments.
- A pixel is kept when all of the following hold:
  - y1 ≤ row < y1+rows*step, and row phase = 0
  - x1 ≤ col < x1+cols*step, and col phase = 0
  - Phases are step-modulo counters reset at y1 and x1. No divider is used.
  - Only kept pixels are written to the FIFO. Dropped pixels are still consumed at full rate.
- The final kept pixel (last window row, last window column) is written with its last flag set.
- Accepting the raster pixel (IN_ROWS-1, IN_COLS-1) moves the state to DRAIN and drops in_ready.
- DRAIN: wait for the FIFO to empty, then pulse frame_done and return to IDLE. The next config can be accepted in the cycle after frame_done.
- FIFO: 2 entries of {last, data}, with a registered output. out_data and out_last hold stable while out_valid && !out_ready.
  - A simultaneous push and pop at count=2 cannot occur, because in_ready=0 at count=2.
  - A simultaneous push and pop at count=1 leaves the count unchanged.
- No arithmetic is applied to pixel data. Every channel passes bit-exact.

## Timing
- Reset values: state IDLE, counters 0, FIFO empty, out_valid=0, out_last=0, out_data=0, in_ready=0, cfg_ready=0, cfg_error=0, frame_done=0.
- A reset asserted mid-frame discards FIFO contents. Outputs reach their reset values in the cycle after the reset edge.
- Config latency: cfg handshake at cycle t; in_ready may be 1 from t+1.
- Data latency: a kept pixel accepted at edge t is on out_data with out_valid=1 after edge t, i.e. 1 cycle.
- Throughput is 1 pixel per cycle when out_ready stays high.
- cfg_error asserts the cycle after the rejected offer and lasts one cycle.
- frame_done asserts the cycle after the FIFO goes empty in DRAIN.
- in_ready and cfg_ready are registered-state functions only. They never combinationally depend on in_valid, out_ready or cfg_valid.

## Test plan
- Default window: in_data = raster index, y1=10, x1=10, rows=20, cols=20, step=1, out_ready=1, in_valid=1. Required: 400 outputs, first 410, last 1189 with out_last=1 on it only, and exactly one frame_done.
- Step 2: y1=0, x1=0, rows=20, cols=20, step=2. Required: output k = 80*(k/20) + 2*(k%20), last 1558 with out_last. Stride 3 with y1=1, x1=2, rows=13, cols=12 ends at 37*40+35=1515.
- Random in_valid and out_ready (50% each) on scenario 1. Required: the identical 400-value sequence with no drop or duplicate, and out_data/out_last stable during every stall.
- Illegal config: y1=30, rows=20, step=1. Required: a one-cycle cfg_error, in_ready stays 0 and no output. Then offer the legal scenario 1 config; it is accepted and produces the correct frame.
- CHANNELS=3, with channel c = index+c*1000 (mod 4096). Required: all three channels are bit-exact at their packed positions.
- Reset after 500 input handshakes in scenario 1. Required: out_valid=0 and cfg_ready=0 during reset, cfg_ready=1 after. A new frame then produces exactly 400 outputs starting at 410.
